// File: rtl/switch_reader.sv
// Debounced 16-bit switch bank with a memory-mapped read port, sticky change flags and an irq.
// Each bit is synchronized, then committed after DEBOUNCE_CYCLES consecutive mismatching samples.
module switch_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] switches,
  input  logic [31:0] writeData,
  input  logic        writeEnable,
  input  logic        readEnable,
  input  logic [29:0] memAddress,
  output logic [31:0] readData,
  output logic        irq
);

  localparam logic [19:0] LAST = 20'(DEBOUNCE_CYCLES - 1);

  logic [15:0] sync1_q, sync2_q;
  logic [15:0] stable_q, stable_d;
  logic [15:0] changed_q, changed_d;
  logic        irq_q, irq_d;
  logic [19:0] cnt_q [16];
  logic [19:0] cnt_d [16];

  // Only the low two address bits and the low half of write data are decoded.
  logic unused_bits;
  assign unused_bits = ^{memAddress[29:2], writeData[31:16]};

  always_comb begin
    stable_d  = stable_q;
    changed_d = changed_q;
    cnt_d     = cnt_q;
    if (writeEnable && memAddress[1:0] == 2'd1) begin
      changed_d = changed_q & ~writeData[15:0];
    end
    // A commit sets its flag after the clear, so set wins over a same-edge W1C.
    for (int i = 0; i < 16; i++) begin
      if (sync2_q[i] == stable_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= LAST) begin
        stable_d[i]  = sync2_q[i];
        cnt_d[i]     = '0;
        changed_d[i] = 1'b1;
      end else begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
    irq_d = |changed_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      stable_q  <= '0;
      changed_q <= '0;
      irq_q     <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= switches;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      changed_q <= changed_d;
      irq_q     <= irq_d;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_comb begin
    readData = '0;
    if (readEnable) begin
      case (memAddress[1:0])
        2'd0:    readData = {16'b0, stable_q};
        2'd1:    readData = {16'b0, changed_q};
        2'd2:    readData = {16'b0, sync2_q};
        default: readData = '0;
      endcase
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_switch_reader.sv
// Scoreboarded bench for switch_reader: directed scenarios then random traffic vs a sample-window model.
module tb_switch_reader;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] switches = '0;
  logic [31:0] writeData = '0;
  logic        writeEnable = 1'b0;
  logic        readEnable = 1'b0;
  logic [29:0] memAddress = '0;
  logic [31:0] readData;
  logic        irq;

  switch_reader #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .switches(switches), .writeData(writeData),
    .writeEnable(writeEnable), .readEnable(readEnable), .memAddress(memAddress),
    .readData(readData), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  int   cyc    = 0;

  // Reference model: raw switch samples per edge; a bit commits when the last D
  // samples seen at the synchronizer output all disagree with the committed level.
  logic [15:0] hist[$];
  logic [15:0] m_stable  = '0;
  logic [15:0] m_changed = '0;
  logic        m_irq     = 1'b0;

  function automatic void model_reset();
    hist.delete();
    for (int k = 0; k < D + 2; k++) hist.push_back(16'h0);
    m_stable  = '0;
    m_changed = '0;
    m_irq     = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(logic re, logic [1:0] a);
    if (!re) return 32'h0;
    case (a)
      2'd0:    return {16'h0, m_stable};
      2'd1:    return {16'h0, m_changed};
      2'd2:    return {16'h0, hist[hist.size() - 2]};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_edge(logic r, logic [15:0] sw, logic we, logic [1:0] a,
                                     logic [31:0] wd);
    logic [15:0] commit;
    int n;
    if (r) begin
      model_reset();
      return;
    end
    n = hist.size();
    commit = '0;
    for (int i = 0; i < 16; i++) begin
      bit all_diff = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (hist[n - k][i] == m_stable[i]) all_diff = 1'b0;
      commit[i] = all_diff;
    end
    m_stable  = m_stable ^ commit;
    if (we && a == 2'd1) m_changed = m_changed & ~wd[15:0];
    m_changed = m_changed | commit;
    m_irq     = |m_changed;
    hist.push_back(sw);
    void'(hist.pop_front());
  endfunction

  task automatic cycle(input logic r, input logic [15:0] sw, input logic re,
                       input logic we, input logic [1:0] a, input logic [31:0] wd);
    exp_t e;
    @(negedge clk);
    rst         = r;
    switches    = sw;
    readEnable  = re;
    writeEnable = we;
    memAddress  = {28'($urandom), a};
    writeData   = wd;
    e.rd  = model_read(re, a);
    e.irq = m_irq;
    e.cyc = cyc;
    sb.push_back(e);
    model_edge(r, sw, we, a, wd);
    cyc++;
  endtask

  task automatic rd(input logic [15:0] sw, input logic [1:0] a);
    cycle(1'b0, sw, 1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr(input logic [15:0] sw, input logic re, input logic [1:0] ra,
                    input logic [31:0] wd);
    cycle(1'b0, sw, re, 1'b1, ra, wd);
  endtask

  // Monitor: compares the DUT outputs of each cycle against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        total++;
        if (readData === e.rd) passed++;
        else $display("FAIL readData cyc=%0d got=%h exp=%h", e.cyc, readData, e.rd);
        total++;
        if (irq === e.irq) passed++;
        else $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, irq, e.irq);
      end
    end
  end

  initial begin
    logic [15:0] sw;
    model_reset();
    // Reset and idle register reads.
    cycle(1'b1, 16'h0, 1'b1, 1'b0, 2'd0, 32'h0);
    cycle(1'b1, 16'h0, 1'b1, 1'b0, 2'd1, 32'h0);
    for (int a = 0; a < 4; a++) rd(16'h0, 2'(a));
    // Single switch held: commits 2 + D edges after first sample.
    for (int k = 0; k < 8; k++) rd(16'h0001, 2'(k % 3));
    rd(16'h0001, 2'd0);
    rd(16'h0001, 2'd1);
    // Short pulse on bit 3 must be rejected, though visible in RAW.
    for (int k = 0; k < 3; k++) rd(16'h0009, 2'd2);
    for (int k = 0; k < 8; k++) rd(16'h0001, 2'(k % 3));
    // Make changed = 0x5, then clear bit 2 and bit 0 separately.
    for (int k = 0; k < 8; k++) rd(16'h0005, 2'd1);
    wr(16'h0005, 1'b1, 2'd1, 32'hFFFF_0004);
    rd(16'h0005, 2'd1);
    wr(16'h0005, 1'b1, 2'd1, 32'h0000_0001);
    rd(16'h0005, 2'd1);
    // W1C of bit 5 on every edge, including the one where it commits.
    for (int k = 0; k < 8; k++) wr(16'h0025, 1'b1, 2'd1, 32'h0000_0020);
    rd(16'h0025, 2'd1);
    // Writes to other addresses do nothing.
    for (int a = 0; a < 4; a++) if (a != 1) wr(16'h0025, 1'b1, 2'(a), 32'hFFFF_FFFF);
    rd(16'h0025, 2'd1);
    // Reset mid-debounce of bit 15; readEnable low must give zero.
    wr(16'h0000, 1'b1, 2'd1, 32'h0000_FFFF);
    for (int k = 0; k < 8; k++) rd(16'h0000, 2'd0);
    cycle(1'b0, 16'h8000, 1'b1, 1'b0, 2'd0, 32'h0);
    cycle(1'b0, 16'h8000, 1'b1, 1'b0, 2'd2, 32'h0);
    cycle(1'b0, 16'h8000, 1'b1, 1'b0, 2'd2, 32'h0);
    cycle(1'b0, 16'h8000, 1'b1, 1'b0, 2'd0, 32'h0);
    cycle(1'b1, 16'h8000, 1'b1, 1'b0, 2'd0, 32'h0);
    for (int k = 0; k < 8; k++) cycle(1'b0, 16'h8000, 1'b0, 1'b0, 2'd0, 32'h0);
    for (int k = 0; k < 3; k++) rd(16'h8000, 2'(k));
    // Random traffic.
    sw = 16'h8000;
    for (int k = 0; k < 1500; k++) begin
      logic r;
      if ($urandom_range(0, 7) == 0) sw = sw ^ 16'($urandom & $urandom & $urandom);
      r = ($urandom_range(0, 299) == 0);
      cycle(r, sw, 1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
            (($urandom_range(0, 3) == 0) ? $urandom : ($urandom & $urandom & $urandom)));
    end
    @(negedge clk);
    #3;
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 1000, number of consecutive clk edges a synchronized switch level must differ from the committed value before it is accepted; legal range 1..2^20-1.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 switches  input  16  raw board switch levels, asynchronous to clk.
REQ-005 writeData  input  32  bus write data.
REQ-006 writeEnable  input  1  bus write strobe, one cycle per access.
REQ-007 readEnable  input  1  bus read strobe.
REQ-008 memAddress  input  30  word address; only memAddress[1:0] decoded.
REQ-009 readData  output  32  bus read data, combinational.
REQ-010 irq  output  1  registered, high while any change flag is set.

Function
REQ-011 Each switches bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-012 Per bit: 20-bit counter cnt[i] and committed level stable[i].
REQ-013 When sync2[i] == stable[i], cnt[i] SHALL clear to 0 on the next edge.
REQ-014 When sync2[i] != stable[i] and cnt[i] < DEBOUNCE_CYCLES-1, cnt[i] SHALL increment.
REQ-015 When sync2[i] != stable[i] and cnt[i] == DEBOUNCE_CYCLES-1, on that edge stable[i] <= sync2[i], cnt[i] <= 0, changed[i] <= 1.
REQ-016 Latency: a clean level change on switches[i] held steady SHALL appear in stable[i] exactly 2 + DEBOUNCE_CYCLES edges after the first edge that samples it.
REQ-017 A mismatch lasting fewer than DEBOUNCE_CYCLES consecutive edges at sync2 SHALL leave stable[i] and changed[i] unchanged (glitch rejected, counter restarts from 0).
REQ-018 changed[15:0] flags SHALL be sticky: set by REQ-015, cleared only by write-1-to-clear or reset.
REQ-019 Register map (memAddress[1:0]): 0 = STATE, read {16'b0, stable}; 1 = CHANGED, read {16'b0, changed}; 2 = RAW, read {16'b0, sync2}; 3 = reserved, read 32'b0.
REQ-020 readData SHALL equal the selected register while readEnable is high and 32'b0 while readEnable is low.
REQ-021 Write with writeEnable high and memAddress[1:0]==1 SHALL clear changed[i] for every i where writeData[i]==1; writeData[31:16] ignored.
REQ-022 Writes to addresses 0, 2, 3 SHALL have no effect.
REQ-023 Simultaneous W1C and set of the same changed[i] in one edge: set SHALL win (flag remains 1).
REQ-024 Reads SHALL have no side effects; a read of CHANGED in the same cycle as a set returns the pre-edge value.
REQ-025 irq SHALL be registered: irq <= |changed_next, so it follows changed by zero cycles of visible skew (updates on the same edge).
REQ-026 readEnable and writeEnable both high in one cycle: read returns pre-edge values, write takes effect at the edge.

Reset
REQ-027 On rst high at an edge: sync1, sync2, stable, changed, all cnt SHALL be 0; irq SHALL be 0.
REQ-028 Reset mid-debounce SHALL discard partial counts; after rst deasserts a held-high switch requires the full 2 + DEBOUNCE_CYCLES edges to commit.
REQ-029 rst SHALL take priority over writeEnable and debounce updates in the same cycle.

Verification (DEBOUNCE_CYCLES=4)
REQ-030 After reset, read addr 0, 1, 2 -> readData 0x00000000 each, irq 0.
REQ-031 switches=0x0001 held -> stable bit 0 set exactly 6 edges later; addr0 reads 0x00000001, addr1 reads 0x00000001, irq 1.
REQ-032 switches[3] pulsed high for 3 cycles then low -> addr0 bit 3 stays 0, changed[3] stays 0; addr2 shows bit 3 high transiently.
REQ-033 changed=0x0005, write addr1 writeData=0x00000004 -> addr1 reads 0x00000001, irq stays 1; write 0x00000001 -> addr1 reads 0, irq 0.
REQ-034 W1C of bit 5 on the same edge bit 5 commits -> addr1 bit 5 reads 1 afterward.
REQ-035 rst asserted 2 edges into a 4-cycle debounce of switches=0x8000 -> after release, stable[15] sets exactly 6 edges after rst deasserts; readEnable low -> readData 0.
